dif_tw_mult_gen: RTL and testbench
==================================

Name: dif_tw_mult_gen

Overview:
- Generic pipelined twiddle multiplier for radix-2 DIF FFT stages. Computes dout = din · W_N^k, where W_N^k = exp(-j2πk/N); inverse mode uses the conjugate.
- Supersedes the fixed 64-point, halt-controlled multiplier. N, data width and coefficient width are parameters; the twiddle index k is supplied directly.
- Uses a valid/ready handshake with backpressure, and a single octant-symmetric coefficient ROM of N/8+1 entries.
- Sits between a butterfly stage and the next stage's delay-commutator.

Parameters:
- DATA_WIDTH, 10, signed width of din_real/din_imag.
- OUT_WIDTH, DATA_WIDTH+1, signed width of dout_real/dout_imag.
- TW_WIDTH, 12, signed coefficient width. Coefficients are scaled by 2^(TW_WIDTH-2), so +1.0 is exact.
- LOG2_N, 6, log2 of FFT size. Legal range 3..12.
- ROUND, 1, output scaling mode. 1 = round half-up; 0 = truncate.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept an input this cycle
- in_k  in  LOG2_N  twiddle exponent k, 0..N-1
- in_inverse  in  1  per-sample mode. 1 = multiply by conj(W_N^k)
- din_real  in  DATA_WIDTH  signed real input
- din_imag  in  DATA_WIDTH  signed imaginary input
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts the output
- dout_real  out  OUT_WIDTH  signed real result
- dout_imag  out  OUT_WIDTH  signed imaginary result

Behaviour:
- Reset: rst_n is synchronous and active-low; clk is the clock. On reset, every stage valid bit, out_valid, dout_real and dout_imag clear to 0. Reset mid-stream discards all in-flight samples; nothing emerges afterwards.
- Handshake:
  - adv = !out_valid || out_ready; in_ready = adv.
  - A transfer occurs on in_valid && in_ready.
  - All four stages advance together on adv and hold on !adv. Bubbles carry valid=0.
  - Outputs stay stable while out_valid && !out_ready.
- Latency: exactly 4 cycles from an accepted input to out_valid, with no stalls. Throughput is 1 sample/cycle.
- S1 (index decode): M = N/8; o = k / M (octant 0..7); r = k mod M.
  - Even o: rom_addr = r.
  - Odd o: rom_addr = M - r.
  - Register o, rom_addr, inverse and din.
- S2 (ROM and octant map): ROM returns c = round(2^(TW_WIDTH-2)·cos(2π·a/N)) and s = round(2^(TW_WIDTH-2)·sin(2π·a/N)), where a = rom_addr. Both are ≥ 0, a = 0..M. Map (c, s) to (C, S) per octant:
  - o0 → (c, s)
  - o1 → (s, c)
  - o2 → (-s, c)
  - o3 → (-c, s)
  - o4 → (-c, -s)
  - o5 → (-s, -c)
  - o6 → (s, -c)
  - o7 → (c, -s)
  - If inverse, negate S.
  - Register C, S and din.
- S3 (products): register pr = xr·C, ps = xi·S, qr = xi·C, qs = xr·S. Each is full width DATA_WIDTH+TW_WIDTH, with no truncation.
- S4 (combine):
  - yr = pr + ps; yi = qr - qs, at width DATA_WIDTH+TW_WIDTH+1.
  - Shift right arithmetically by TW_WIDTH-2. When ROUND=1, first add 2^(TW_WIDTH-3).
  - Saturate to OUT_WIDTH (clip to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]) and register onto dout.
- Exactness: k = 0 and the quarter-turn cases (k = N/4, N/2, 3N/4) are bit-exact (sign-extended swaps/negations), including with ROUND=1.
- in_k and in_inverse are sampled only on transfer. Values on non-transfer cycles are ignored.
- Simultaneous out_ready and in_valid with a full pipeline: one sample leaves and one enters in the same cycle.

Decomposition:
- Package dif_tw_pkg holds:
  - octant codes OCT0..OCT7;
  - function log2_n → M;
  - function tw_coef(addr, log2_n, tw_width, is_sin), evaluated at elaboration with $cos/$sin;
  - saturate/round helper functions.
- Sub-module dif_tw_rom (params LOG2_N, TW_WIDTH): M+1-entry constant table, 1-cycle registered (c, s) output, with an enable tied to adv.

Test Plan (DATA_WIDTH=10, TW_WIDTH=12, LOG2_N=6, ROUND=1):
- k=0, din=(100,-50), fwd → dout=(100,-50); out_valid exactly 4 cycles after acceptance.
- k=16, din=(100,-50): fwd → (-50,-100); inverse → (50,100). k=32, din=(-512,-512) → (512,512).
- k=8, din=(256,0), fwd → C=S=724, dout=(181,-181). Sweep k=0..63 with din=(300,200) against a real-valued model: |error| ≤ 1 LSB.
- Backpressure: out_ready=0, 6 back-to-back inputs → exactly 4 accepted, in_ready=0 and dout stable. Then out_ready=1 → 6 outputs delivered in order, no loss or duplication.
- Random in_valid/out_ready toggling over 1000 samples with mixed in_inverse → output stream matches the model in order.
- Assert rst_n=0 with 3 samples in flight → next cycle out_valid=0 and dout=(0,0). No stale outputs after release.

Source files
------------

// File: rtl/dif_tw_pkg.sv
// Shared definitions for the DIF twiddle multiplier.
//   oct_t       : octant code of the twiddle angle (k / (N/8))
//   m_of        : entries per octant, M = N/8
//   tw_coef     : elaboration-time cos/sin table value, scaled by 2^(tw_width-2)
//   round_shift : arithmetic right shift with optional half-up rounding
//   sat_clip    : clip a value to a signed range of a given width
package dif_tw_pkg;

    typedef enum logic [2:0] {
        OCT0 = 3'd0,
        OCT1 = 3'd1,
        OCT2 = 3'd2,
        OCT3 = 3'd3,
        OCT4 = 3'd4,
        OCT5 = 3'd5,
        OCT6 = 3'd6,
        OCT7 = 3'd7
    } oct_t;

    function automatic int m_of(input int log2_n);
        return 1 << (log2_n - 3);
    endfunction

    // Angles stay within the first octant, so both values are >= 0 and
    // adding 0.5 before truncation is a plain round-to-nearest.
    function automatic int tw_coef(input int addr, input int log2_n,
                                   input int tw_width, input bit is_sin);
        real ang;
        real scale;
        real v;
        ang   = 2.0 * 3.14159265358979323846 * real'(addr) / real'(1 << log2_n);
        scale = real'(1 << (tw_width - 2));
        v     = is_sin ? scale * $sin(ang) : scale * $cos(ang);
        return $rtoi(v + 0.5);
    endfunction

    function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                       input int sh, input bit rnd);
        logic signed [63:0] bias;
        bias = rnd ? (64'sd1 <<< (sh - 1)) : 64'sd0;
        return (v + bias) >>> sh;
    endfunction

    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v,
                                                    input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/dif_tw_rom.sv
// First-octant twiddle table, M+1 entries (angles 0..pi/4), registered output.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : advance enable (pipeline advance)
//   addr       : table address 0..M
//   cos_q      : round(2^(TW_WIDTH-2) * cos(2*pi*addr/N)), non-negative
//   sin_q      : round(2^(TW_WIDTH-2) * sin(2*pi*addr/N)), non-negative
module dif_tw_rom
    import dif_tw_pkg::*;
#(
    parameter int LOG2_N   = 6,
    parameter int TW_WIDTH = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [LOG2_N-3:0]   addr,
    output logic [TW_WIDTH-1:0] cos_q,
    output logic [TW_WIDTH-1:0] sin_q
);

    localparam int M = m_of(LOG2_N);

    logic [TW_WIDTH-1:0] cos_tab [0:M];
    logic [TW_WIDTH-1:0] sin_tab [0:M];

    for (genvar a = 0; a <= M; a++) begin : g_tab
        localparam int COS_V = tw_coef(a, LOG2_N, TW_WIDTH, 1'b0);
        localparam int SIN_V = tw_coef(a, LOG2_N, TW_WIDTH, 1'b1);
        assign cos_tab[a] = TW_WIDTH'(COS_V);
        assign sin_tab[a] = TW_WIDTH'(SIN_V);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cos_q <= '0;
            sin_q <= '0;
        end else if (en) begin
            cos_q <= cos_tab[addr];
            sin_q <= sin_tab[addr];
        end
    end

endmodule

// File: rtl/dif_tw_mult_gen.sv
// Pipelined twiddle multiplier for radix-2 DIF FFT stages:
// dout = din * exp(-j*2*pi*k/N), or the conjugate twiddle when in_inverse=1.
// Four stages (index decode, ROM + octant map, products, combine/round/saturate)
// advance together under a valid/ready handshake.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : input handshake
//   in_k, in_inverse     : twiddle exponent and conjugate select
//   din_real / din_imag  : signed input sample
//   out_valid / out_ready: output handshake
//   dout_real/dout_imag  : signed result, OUT_WIDTH bits
module dif_tw_mult_gen
    import dif_tw_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int OUT_WIDTH  = DATA_WIDTH + 1,
    parameter int TW_WIDTH   = 12,
    parameter int LOG2_N     = 6,
    parameter int ROUND      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LOG2_N-1:0]     in_k,
    input  logic                  in_inverse,
    input  logic [DATA_WIDTH-1:0] din_real,
    input  logic [DATA_WIDTH-1:0] din_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  dout_real,
    output logic [OUT_WIDTH-1:0]  dout_imag
);

    localparam int M   = m_of(LOG2_N);
    localparam int A_W = LOG2_N - 2;
    localparam int P_W = DATA_WIDTH + TW_WIDTH;
    localparam int Y_W = P_W + 1;

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // S1: octant and mirrored first-octant address
    logic [2:0]     oct_k;
    logic [A_W-1:0] r_a;
    logic [A_W-1:0] a_a;

    always_comb begin
        oct_k = in_k[LOG2_N-1 -: 3];
        r_a   = A_W'(in_k) & A_W'(M - 1);
        a_a   = oct_k[0] ? (A_W'(M) - r_a) : r_a;
    end

    logic                         s1_valid;
    oct_t                         s1_oct;
    logic [A_W-1:0]               s1_addr;
    logic                         s1_inv;
    logic signed [DATA_WIDTH-1:0] s1_xr;
    logic signed [DATA_WIDTH-1:0] s1_xi;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_oct   <= oct_t'(oct_k);
            s1_addr  <= a_a;
            s1_inv   <= in_inverse;
            s1_xr    <= signed'(din_real);
            s1_xi    <= signed'(din_imag);
        end
    end

    // S2: ROM register runs alongside the S2 side-band registers
    logic [TW_WIDTH-1:0] rom_cos;
    logic [TW_WIDTH-1:0] rom_sin;

    dif_tw_rom #(
        .LOG2_N   (LOG2_N),
        .TW_WIDTH (TW_WIDTH)
    ) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv),
        .addr  (s1_addr),
        .cos_q (rom_cos),
        .sin_q (rom_sin)
    );

    logic                         s2_valid;
    oct_t                         s2_oct;
    logic                         s2_inv;
    logic signed [DATA_WIDTH-1:0] s2_xr;
    logic signed [DATA_WIDTH-1:0] s2_xi;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_oct   <= s1_oct;
            s2_inv   <= s1_inv;
            s2_xr    <= s1_xr;
            s2_xi    <= s1_xi;
        end
    end

    // Octant map: W = C - jS with C = cos(theta), S = sin(theta)
    logic signed [TW_WIDTH-1:0] c_s;
    logic signed [TW_WIDTH-1:0] s_s;
    logic signed [TW_WIDTH-1:0] cc;
    logic signed [TW_WIDTH-1:0] ss;

    assign c_s = signed'(rom_cos);
    assign s_s = signed'(rom_sin);

    always_comb begin
        cc = c_s;
        ss = s_s;
        case (s2_oct)
            OCT0: begin cc =  c_s; ss =  s_s; end
            OCT1: begin cc =  s_s; ss =  c_s; end
            OCT2: begin cc = -s_s; ss =  c_s; end
            OCT3: begin cc = -c_s; ss =  s_s; end
            OCT4: begin cc = -c_s; ss = -s_s; end
            OCT5: begin cc = -s_s; ss = -c_s; end
            OCT6: begin cc =  s_s; ss = -c_s; end
            OCT7: begin cc =  c_s; ss = -s_s; end
            default: ;
        endcase
        if (s2_inv) ss = -ss;
    end

    // S3: full-width products
    logic                  s3_valid;
    logic signed [P_W-1:0] pr;
    logic signed [P_W-1:0] ps;
    logic signed [P_W-1:0] qr;
    logic signed [P_W-1:0] qs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
        end else if (adv) begin
            s3_valid <= s2_valid;
            pr       <= P_W'(s2_xr) * P_W'(cc);
            ps       <= P_W'(s2_xi) * P_W'(ss);
            qr       <= P_W'(s2_xi) * P_W'(cc);
            qs       <= P_W'(s2_xr) * P_W'(ss);
        end
    end

    // S4: combine, scale back by 2^(TW_WIDTH-2), saturate
    logic signed [Y_W-1:0] yr_w;
    logic signed [Y_W-1:0] yi_w;

    assign yr_w = Y_W'(pr) + Y_W'(ps);
    assign yi_w = Y_W'(qr) - Y_W'(qs);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout_real <= '0;
            dout_imag <= '0;
        end else if (adv) begin
            out_valid <= s3_valid;
            if (s3_valid) begin
                dout_real <= OUT_WIDTH'(sat_clip(round_shift(64'(yr_w), TW_WIDTH - 2, ROUND != 0), OUT_WIDTH));
                dout_imag <= OUT_WIDTH'(sat_clip(round_shift(64'(yi_w), TW_WIDTH - 2, ROUND != 0), OUT_WIDTH));
            end
        end
    end

endmodule

// File: tb/tb_dif_tw_mult_gen.sv
module tb_dif_tw_mult_gen;

    localparam int DW = 10;
    localparam int OW = 11;
    localparam int TW = 12;
    localparam int LN = 6;
    localparam real PI = 3.14159265358979323846;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [LN-1:0] in_k = '0;
    logic          in_inverse = 1'b0;
    logic [DW-1:0] din_real = '0;
    logic [DW-1:0] din_imag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] dout_real;
    logic [OW-1:0] dout_imag;

    always #5 clk = ~clk;

    dif_tw_mult_gen #(
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW),
        .TW_WIDTH   (TW),
        .LOG2_N     (LN),
        .ROUND      (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_k       (in_k),
        .in_inverse (in_inverse),
        .din_real   (din_real),
        .din_imag   (din_imag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dout_real  (dout_real),
        .dout_imag  (dout_imag)
    );

    typedef struct {
        int k;
        bit inv;
        int xr;
        int xi;
        int er;
        int ei;
    } vec_t;

    typedef struct {
        real yr;
        real yi;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    bit   sb_on = 1'b0;
    int   n_out = 0;
    logic obs_ov = 1'b0;
    logic obs_ir = 1'b0;
    logic acc_now = 1'b0;
    int   obs_r = 0;
    int   obs_i = 0;
    bit   prev_stall = 1'b0;
    int   prev_r = 0;
    int   prev_i = 0;
    vec_t vecs[13];

    function automatic int so(input logic [OW-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic exp_t model(input int k, input bit inv, input int xr, input int xi);
        exp_t e;
        real th, c, s;
        th = 2.0 * PI * real'(k) / 64.0;
        c  = $cos(th);
        s  = $sin(th);
        if (inv) s = -s;
        e.yr = real'(xr) * c + real'(xi) * s;
        e.yi = real'(xi) * c - real'(xr) * s;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic chk_tol(input string nm, input int act, input real req);
        real d;
        total++;
        d = real'(act) - req;
        if (d < 0.0) d = -d;
        if (d > 1.0) begin
            bad++;
            $display("FAIL %s: got %0d expected %f within 1", nm, act, req);
        end
    endtask

    // One clock: observe and score at the negedge, then step past the posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        obs_ov  = out_valid;
        obs_ir  = in_ready;
        acc_now = rst_n && in_valid && in_ready;
        obs_r   = so(dout_real);
        obs_i   = so(dout_imag);
        if (rst_n) begin
            if (prev_stall) begin
                chk("hold_valid", int'(obs_ov), 1);
                chk("hold_real", obs_r, prev_r);
                chk("hold_imag", obs_i, prev_i);
            end
            if (sb_on) begin
                if (out_valid && out_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected: got output (%0d,%0d) expected none", obs_r, obs_i);
                    end else begin
                        e = exp_q.pop_front();
                        chk_tol("sb_real", obs_r, e.yr);
                        chk_tol("sb_imag", obs_i, e.yi);
                        n_out++;
                    end
                end
                if (acc_now)
                    exp_q.push_back(model(int'(in_k), in_inverse,
                                          int'($signed(din_real)), int'($signed(din_imag))));
            end
        end
        prev_stall = rst_n && out_valid && !out_ready;
        prev_r = obs_r;
        prev_i = obs_i;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input bit inv, input int xr, input int xi);
        in_k       = LN'(k);
        in_inverse = inv;
        din_real   = DW'(xr);
        din_imag   = DW'(xi);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cnt;
        drive(v.k, v.inv, v.xr, v.xi);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        chk($sformatf("vec%0d_accept", idx), int'(acc_now), 1);
        in_valid = 1'b0;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!obs_ov && cnt < 12);
        chk($sformatf("vec%0d_latency", idx), cnt, 4);
        chk($sformatf("vec%0d_real", idx), obs_r, v.er);
        chk($sformatf("vec%0d_imag", idx), obs_i, v.ei);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, cyc, ov_cnt;

        //          k   inv  xr    xi    er    ei
        vecs[0]  = '{0,  1'b0, 100,  -50,  100,  -50};
        vecs[1]  = '{16, 1'b0, 100,  -50,  -50, -100};
        vecs[2]  = '{16, 1'b1, 100,  -50,   50,  100};
        vecs[3]  = '{32, 1'b0, -512, -512, 512,  512};
        vecs[4]  = '{8,  1'b0, 256,  0,    181, -181};
        vecs[5]  = '{8,  1'b1, 256,  0,    181,  181};
        vecs[6]  = '{24, 1'b0, 256,  0,   -181, -181};
        vecs[7]  = '{48, 1'b0, 100,  -50,   50,  100};
        vecs[8]  = '{0,  1'b1, -1,   1,     -1,    1};
        vecs[9]  = '{1,  1'b0, 100,  0,    100,  -10};
        vecs[10] = '{7,  1'b0, 100,  0,     77,  -63};
        vecs[11] = '{57, 1'b0, 100,  0,     77,   63};
        vecs[12] = '{48, 1'b1, 511, -512, -512, -511};

        // reset state
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_out_valid", int'(obs_ov), 0);
        chk("rst_in_ready", int'(obs_ir), 1);
        chk("rst_dout_real", obs_r, 0);
        chk("rst_dout_imag", obs_i, 0);

        // directed exact vectors
        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // full k sweep, back-to-back, against the real-valued model
        sb_on = 1'b1;
        n_out = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            drive(k, 1'b0, 300, 200);
            in_valid = 1'b1;
            tick();
            chk($sformatf("sweep_accept_k%0d", k), int'(acc_now), 1);
        end
        in_valid = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("sweep_count", n_out, 64);

        // backpressure: 6 back-to-back samples into a blocked output
        n_out = 0;
        sent = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drive(0, 1'b0, 10 * (sent + 1), -10 * (sent + 1));
            in_valid = (sent < 6);
            tick();
            if (acc_now) sent++;
        end
        chk("bp_accepted", sent, 4);
        chk("bp_in_ready", int'(obs_ir), 0);
        chk("bp_out_valid", int'(obs_ov), 1);
        out_ready = 1'b1;
        cyc = 0;
        while ((sent < 6 || exp_q.size() > 0) && cyc < 30) begin
            if (sent < 6) begin
                drive(0, 1'b0, 10 * (sent + 1), -10 * (sent + 1));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (acc_now) sent++;
            cyc++;
        end
        chk("bp_delivered", n_out, 6);

        // random valid/ready traffic with mixed mode
        n_out = 0;
        sent = 0;
        cyc = 0;
        while ((sent < 1000 || exp_q.size() > 0) && cyc < 20000) begin
            if (sent < 1000) begin
                drive(int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 800)) - 400, int'($urandom_range(0, 800)) - 400);
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            tick();
            if (acc_now) sent++;
            cyc++;
        end
        chk("rand_sent", sent, 1000);
        chk("rand_delivered", n_out, 1000);

        // reset with three samples in flight
        sb_on = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(16, 1'b0, 100 + i, -50);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("midrst_out_valid", int'(obs_ov), 0);
        chk("midrst_dout_real", obs_r, 0);
        chk("midrst_dout_imag", obs_i, 0);
        rst_n = 1'b1;
        ov_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_ov) ov_cnt++;
        end
        chk("midrst_stale_outputs", ov_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
